// File: rtl/hwpe_dma_pkg.sv
// Shared types and constants for the HWPE DMA loader.
// Holds the FSM state encoding, default widths, the stream-to-word
// packing ratio, the region descriptor layout, and width-check helpers.
package hwpe_dma_pkg;

  localparam int HWPE_ADDR_W = 16;
  localparam int DMA_LEN_W   = 12;
  localparam int DMA_IN_W    = 32;
  localparam int DMA_OUT_W   = 64;
  localparam int RATIO       = DMA_OUT_W / DMA_IN_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_RUN,
    ST_FIN
  } dma_state_e;

  // One destination region: start byte address and length in output words.
  typedef struct packed {
    logic [HWPE_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]   len;
  } desc_t;

  // The input stream must tile the output word exactly.
  function automatic bit width_ok(input int in_w, input int out_w);
    return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0);
  endfunction

  function automatic int ratio_of(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/hwpe_dma_packer.sv
// Packs IN_W-bit stream words into one OUT_W-bit word, lane 0 first.
// 'full' flags the push that completes a word; 'word' is the completed
// word on that cycle (the incoming lane merged over the stored lanes).
// 'clear' discards any partially packed word.
module hwpe_dma_packer
  import hwpe_dma_pkg::*;
#(
  parameter int IN_W  = DMA_IN_W,
  parameter int OUT_W = DMA_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [IN_W-1:0]  in_data,
  output logic             full,
  output logic [OUT_W-1:0] word
);

  localparam int LANES = ratio_of(IN_W, OUT_W);
  localparam int SUB_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(LANES - 1);

  logic [OUT_W-1:0] lanes_q;
  logic [SUB_W-1:0] sub;

  assign full = push && (sub == LAST_SUB);

  // Completed word: stored lanes with the current input in lane 'sub'.
  always_comb begin
    word = lanes_q;
    word[sub*IN_W +: IN_W] = in_data;
  end

  // Lane counter; restarts at lane 0 after a full word or a clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sub <= '0;
    end else if (push) begin
      sub <= full ? '0 : sub + 1'b1;
    end
  end

  // Lane storage; stale lanes are always overwritten before reuse.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
    end else if (push) begin
      lanes_q[sub*IN_W +: IN_W] <= in_data;
    end
  end

endmodule

// File: rtl/hwpe_dma_loader.sv
// HWPE DMA loader: packs a narrow input stream into SRAM words and writes
// them region by region following a programmable descriptor list.
// Optional feature macro: HWPE_DMA_CKSUM_EN (running 32-bit checksum of
// every written word; cksum is tied to 0 when the macro is undefined).
//
// Stream handshake: a word transfers on a rising clk edge where s_valid and
// s_ready are both high; s_data must be stable while s_valid is high, and
// s_ready depends only on the FSM state, never on s_valid.
module hwpe_dma_loader
  import hwpe_dma_pkg::*;
#(
  parameter int ADDR_W     = HWPE_ADDR_W,
  parameter int IN_W       = DMA_IN_W,
  parameter int OUT_W      = DMA_OUT_W,
  parameter int NUM_REGION = 4,
  parameter int LEN_W      = DMA_LEN_W,
  localparam int IDX_W     = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wen,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  output logic              dma_wen,
  output logic [ADDR_W-1:0] dma_wa,
  output logic [OUT_W-1:0]  dma_wd,
  output logic [31:0]       cksum
);

  localparam int STEP = OUT_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGION - 1);

  // Descriptor storage uses the package layout, so widths must match it.
  if (!width_ok(IN_W, OUT_W)) begin : g_width_err
    $error("IN_W must divide OUT_W");
  end
  if (NUM_REGION < 1) begin : g_region_err
    $error("NUM_REGION must be at least 1");
  end
  if ((ADDR_W != HWPE_ADDR_W) || (LEN_W != DMA_LEN_W)) begin : g_desc_err
    $error("ADDR_W/LEN_W must match the descriptor layout");
  end

  dma_state_e        state, state_n;
  desc_t             desc [NUM_REGION];
  logic [IDX_W-1:0]  ri;
  logic [ADDR_W-1:0] wa;
  logic [LEN_W-1:0]  remaining;
  logic              accept, full, cur_skip, cur_last, cfg_ok;
  logic [OUT_W-1:0]  word;

  assign accept   = s_valid && s_ready;
  assign cur_skip = (desc[ri].len == '0);
  assign cur_last = (ri == LAST_IDX);
  assign cfg_ok   = ({{(32-IDX_W){1'b0}}, cfg_idx} < 32'(NUM_REGION));
  assign busy     = (state == ST_SEL) || (state == ST_RUN);
  assign done     = (state == ST_FIN);
  assign s_ready  = (state == ST_RUN);

  // Leaving RUN (including reset) drops any partially packed word.
  hwpe_dma_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_RUN),
    .push    (accept),
    .in_data (s_data),
    .full    (full),
    .word    (word)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic: walk descriptors in order, skipping empty ones.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_SEL;
      ST_SEL: begin
        if (!cur_skip)     state_n = ST_RUN;
        else if (cur_last) state_n = ST_FIN;
      end
      ST_RUN: begin
        if (full && (remaining == LEN_W'(1))) state_n = cur_last ? ST_FIN : ST_SEL;
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Descriptor file; writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGION; i++) desc[i] <= '0;
    end else if ((state == ST_IDLE) && cfg_wen && cfg_ok) begin
      desc[cfg_idx] <= '{addr: cfg_addr, len: cfg_len};
    end
  end

  // Region index, write address and remaining-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ri        <= '0;
      wa        <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) ri <= '0;
        ST_SEL: begin
          if (!cur_skip) begin
            wa        <= desc[ri].addr;
            remaining <= desc[ri].len;
          end else if (!cur_last) begin
            ri <= ri + 1'b1;
          end
        end
        ST_RUN: begin
          if (full) begin
            wa        <= wa + ADDR_W'(STEP);
            remaining <= remaining - 1'b1;
            if ((remaining == LEN_W'(1)) && !cur_last) ri <= ri + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM write port, registered one cycle after the completing accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_wen <= 1'b0;
      dma_wa  <= '0;
      dma_wd  <= '0;
    end else begin
      dma_wen <= full;
      if (full) begin
        dma_wa <= wa;
        dma_wd <= word;
      end
    end
  end

`ifdef HWPE_DMA_CKSUM_EN
  localparam int NSLICE = (OUT_W + 31) / 32;

  logic [31:0]          cksum_q, word_sum;
  logic [NSLICE*32-1:0] word_pad;

  // Sum of the 32-bit slices of the word being written.
  always_comb begin
    word_pad = (NSLICE*32)'(word);
    word_sum = '0;
    for (int i = 0; i < NSLICE; i++) word_sum = word_sum + word_pad[i*32 +: 32];
  end

  // Checksum updates on the same edge that raises dma_wen, so it is final by done.
  always_ff @(posedge clk) begin
    if (rst)                             cksum_q <= '0;
    else if ((state == ST_IDLE) && start) cksum_q <= '0;
    else if (full)                       cksum_q <= cksum_q + word_sum;
  end

  assign cksum = cksum_q;
`else
  assign cksum = 32'd0;
`endif

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
Synthesizable DMA front-end for the HWPE local SRAMs. It accepts a narrow input stream from the system bus and packs it into OUT_W-bit words. Packed words are written through the hwpe dma_wen/dma_wa/dma_wd port, following a programmable list of up to NUM_REGION destination descriptors (fmap bank 1, fmap bank 2, kernel, ...). One start pulse fills every programmed region in index order, then raises done.

Parameters:
ADDR_W, 16, SRAM byte-address width; matches HWPE_ADDR_WIDTH.
IN_W, 32, input stream width; must divide OUT_W.
OUT_W, 64, SRAM write width.
NUM_REGION, 4, number of descriptors; must be at least 1.
LEN_W, 12, width of the per-region length field, counted in OUT_W words.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_wen  in  1  write one descriptor
cfg_idx  in  clog2(NUM_REGION)  descriptor index
cfg_addr  in  ADDR_W  region start byte address
cfg_len  in  LEN_W  region length in OUT_W words; 0 means skip
start  in  1  begin a transfer (pulse)
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid and s_ready are both high
s_data  in  IN_W  input word
dma_wen  out  1  SRAM write enable
dma_wa  out  ADDR_W  SRAM byte address
dma_wd  out  OUT_W  SRAM write data
cksum  out  32  running checksum (see Optional Feature)

Behaviour:
- Reset values:
  - busy, done, s_ready, dma_wen: 0.
  - dma_wa, dma_wd, cksum: 0.
  - All descriptors: addr 0, len 0.
  - FSM state: IDLE.
- Reset asserted mid-transfer: all of the above apply in the next cycle. A partially packed word is discarded.
- Configuration:
  - cfg_wen is honoured only in IDLE; it is ignored while busy.
  - cfg_idx >= NUM_REGION is ignored.
- FSM states: IDLE, SEL, RUN, FIN.
  - IDLE -> SEL on start. Sets busy=1 and region index ri=0.
  - SEL:
    - If len[ri]==0: increment ri.
    - If len[ri]!=0: load wa=addr[ri], remaining=len[ri], sub=0, then go to RUN.
    - If ri==NUM_REGION-1 and that region is skipped: go to FIN.
  - RUN:
    - s_ready=1.
    - On each accepted word, s_data goes into lane sub of the pack register. Lane 0 is the LSBs, so the first word received ends up in the low bits.
    - sub increments on each accepted word. At sub==RATIO-1 (RATIO=OUT_W/IN_W):
      - The next cycle shows dma_wen=1, dma_wa=wa, dma_wd=packed word (registered, latency 1).
      - wa increments by OUT_W/8; remaining decrements by 1; sub returns to 0.
    - When remaining reaches 0:
      - s_ready drops in the same cycle as the final accept.
      - If ri is the last index, go to FIN; otherwise increment ri and go to SEL.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- dma_wen is high for exactly one cycle per packed word and is never asserted in IDLE.
- Back-to-back input: with RATIO=2 and s_valid held high, there is one SRAM write every 2 cycles and no bubbles inside a region. Each region switch costs one SEL cycle.
- start while busy is ignored.
- All regions of length 0: start -> SEL cycles -> FIN. done is asserted and no writes occur.
- wa wraps modulo 2^ADDR_W without error.
- Regions are not checked for overlap; later writes overwrite earlier ones.

Optional Feature:
Macro HWPE_DMA_CKSUM_EN.
- Defined: cksum is cleared on start. On each dma_wen, the sum of all 32-bit slices of dma_wd is added to it, modulo 2^32. cksum holds its value after done until the next start or reset.
- Not defined: cksum is constant 0 and no adder logic is built.

Decomposition:
- Shared package hwpe_dma_pkg:
  - FSM state enum.
  - RATIO constant.
  - Descriptor struct {addr, len}.
  - Width-check assertions for IN_W dividing OUT_W.
- One sub-module, hwpe_dma_packer: the IN_W-to-OUT_W lane register, the sub counter, and the full/flush control. The top level owns the descriptor file, FSM and address generation.

Test Plan:
- Single region addr=0x0000, len=4, input words 0x1..0x8 -> 4 writes at 0x00, 0x08, 0x10, 0x18; first dma_wd=0x00000002_00000001; one done pulse.
- Regions 0:(0x0000,2), 1:len 0, 2:(0x8000,1) -> writes at 0x0000, 0x0008, 0x8000 in that order; region 1 produces no write.
- s_valid toggled every other cycle -> same data and addresses as with continuous input, with no write while a packed word is incomplete.
- All regions len 0 -> done within NUM_REGION+2 cycles of start; dma_wen never asserted.
- rst asserted after 3 of 8 input words -> next cycle busy=0, dma_wen=0; a new start after reprogramming fills the region correctly from sub=0.
- With HWPE_DMA_CKSUM_EN: len=1, words 0xFFFFFFFF and 0x00000002 -> cksum=0x00000001; without the macro, cksum=0.
